// File: rtl/axis_decimator.sv
// AXI-Stream decimator by 2^DECIM_LOG2 with a two-entry (main + skid) output buffer.
// Define DECIM_AVG_EN for boxcar averaging; otherwise the closing beat of each group is kept.
module axis_decimator #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DECIM_LOG2             = 3
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);
    localparam int W = C_M00_AXIS_TDATA_WIDTH;

    logic [DECIM_LOG2-1:0] phase;
    logic                  main_valid, main_last, skid_valid, skid_last;
    logic [W-1:0]          main_data, skid_data, word;
    logic                  accept, closing, consume;
    logic                  unused_tstrb;

    assign unused_tstrb = ^s00_axis_tstrb;

    // tready depends only on the skid register, so no path from m00_axis_tready.
    assign s00_axis_tready = ~skid_valid;
    assign accept          = s00_axis_tvalid & ~skid_valid;
    assign closing         = accept & ((&phase) | s00_axis_tlast);
    assign consume         = main_valid & m00_axis_tready;

    assign m00_axis_tvalid = main_valid;
    assign m00_axis_tdata  = main_data;
    assign m00_axis_tlast  = main_last;
    assign m00_axis_tstrb  = '1;

`ifdef DECIM_AVG_EN
    localparam int ACC_W = C_S00_AXIS_TDATA_WIDTH + DECIM_LOG2;
    logic signed [ACC_W-1:0] acc, acc_next;

    assign acc_next = acc + ACC_W'($signed(s00_axis_tdata));
    // Shortened groups still divide by N; the attenuation is intended.
    assign word     = W'(acc_next >>> DECIM_LOG2);

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn)
            acc <= '0;
        else if (closing)
            acc <= '0;
        else if (accept)
            acc <= acc_next;
    end
`else
    assign word = W'(s00_axis_tdata);
`endif

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn)
            phase <= '0;
        else if (closing)
            phase <= '0;
        else if (accept)
            phase <= phase + 1'b1;
    end

    // A closing beat is never accepted while skid is full, so skid->main and a new word never collide.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_last  <= skid_last;
                skid_valid <= 1'b0;
            end else if (closing) begin
                main_data  <= word;
                main_last  <= s00_axis_tlast;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (closing) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= word;
                main_last  <= s00_axis_tlast;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= word;
                skid_last  <= s00_axis_tlast;
            end
        end
    end
endmodule

// File: tb/tb_axis_decimator.sv
// Bench for axis_decimator: directed test-plan sequences plus random traffic against a
// group/queue reference model (averaging expectations when DECIM_AVG_EN is defined).
module tb_axis_decimator;
    localparam int L = 3;
    localparam int N = 1 << L;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tlast, s_tready, m_tready, m_tvalid, m_tlast;
    logic [31:0] s_tdata, m_tdata;
    logic [3:0]  s_tstrb, m_tstrb;

    int checks = 0;
    int errors = 0;

    longint      grp_sum;
    int          grp_cnt;
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [31:0] got_d[$];
    logic        got_l[$];

    always #5 clk = ~clk;

    axis_decimator #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .DECIM_LOG2(L)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready),
        .m00_axis_tready(m_tready),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tstrb(m_tstrb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        grp_sum = 0;
        grp_cnt = 0;
        exp_d.delete();
        exp_l.delete();
    endtask

    // A group closes after N beats or at tlast; its word is the mean (floored, /N) or the last sample.
    task automatic model_accept(input logic [31:0] d, input logic l);
        longint s;
        grp_sum += longint'($signed(d));
        grp_cnt++;
        if (grp_cnt == N || l) begin
`ifdef DECIM_AVG_EN
            s = grp_sum >>> L;
            exp_d.push_back(s[31:0]);
`else
            s = 0;
            exp_d.push_back(d);
`endif
            exp_l.push_back(l);
            grp_sum = 0;
            grp_cnt = 0;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic r,
                        output logic acc);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        @(negedge clk);
        chk("m_tvalid", 32'(m_tvalid), 32'(exp_d.size() > 0));
        chk("s_tready", 32'(s_tready), 32'(exp_d.size() < 2));
        chk("m_tstrb", 32'(m_tstrb), 32'hF);
        if (exp_d.size() > 0) begin
            chk("m_tdata", m_tdata, exp_d[0]);
            chk("m_tlast", 32'(m_tlast), 32'(exp_l[0]));
        end
        acc = v && s_tready;
        if (m_tvalid && r) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
            if (exp_d.size() > 0) begin
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
        end
        if (acc) model_accept(d, l);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic a;
        int   n = 0;
        while (exp_d.size() > 0 && n < 20) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, a);
            n++;
        end
        chk("drain_empty", 32'(exp_d.size()), 32'd0);
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] e[5], input int n);
        chk({tag, "_count"}, 32'(got_d.size()), 32'(n));
        for (int k = 0; k < n && k < got_d.size(); k++)
            chk({tag, "_data"}, got_d[k], e[k]);
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        logic        a;
        logic [31:0] ev[5];
        int          i;
        int          n;

        rst_n = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tstrb = '0; m_tready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd1);
        chk("rst_m_tstrb", 32'(m_tstrb), 32'hF);
        rst_n = 1'b1;

        // Ramp 0..15 with downstream always ready.
        for (int k = 0; k < 16; k++) step(1'b1, 32'(k), 1'b0, 1'b1, a);
        drain();
`ifdef DECIM_AVG_EN
        ev = '{32'd3, 32'd11, 32'd0, 32'd0, 32'd0};
`else
        ev = '{32'd7, 32'd15, 32'd0, 32'd0, 32'd0};
`endif
        chk_seq("ramp", ev, 2);

        // Eight copies of -3, then 1..8.
        for (int k = 0; k < 8; k++) step(1'b1, -32'sd3, 1'b0, 1'b1, a);
        for (int k = 1; k <= 8; k++) step(1'b1, 32'(k), 1'b0, 1'b1, a);
        drain();
`ifdef DECIM_AVG_EN
        ev = '{-32'sd3, 32'd4, 32'd0, 32'd0, 32'd0};
`else
        ev = '{-32'sd3, 32'd8, 32'd0, 32'd0, 32'd0};
`endif
        chk_seq("neg3", ev, 2);

        // Back pressure: 40 stalled cycles, then release until all of 0..39 is through.
        i = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0, a);
            if (a) i++;
        end
        chk("bp_accepted", 32'(i), 32'd16);
        chk("bp_s_tready", 32'(s_tready), 32'd0);
        chk("bp_main", m_tdata, exp_d.size() > 0 ? exp_d[0] : 32'hDEAD);
        n = 0;
        while (i < 40 && n < 200) begin
            step(1'b1, 32'(i), 1'b0, 1'b1, a);
            if (a) i++;
            n++;
        end
        chk("bp_all_in", 32'(i), 32'd40);
        drain();
`ifdef DECIM_AVG_EN
        ev = '{32'd3, 32'd11, 32'd19, 32'd27, 32'd35};
`else
        ev = '{32'd7, 32'd15, 32'd23, 32'd31, 32'd39};
`endif
        chk_seq("bp", ev, 5);

        // Short packet ends at input 3; the next group restarts at phase 0.
        for (int k = 0; k < 12; k++) step(1'b1, 32'(k), k == 3, 1'b1, a);
        drain();
        chk("tlast_first", got_l.size() > 0 ? 32'(got_l[0]) : 32'hDEAD, 32'd1);
        chk("tlast_second", got_l.size() > 1 ? 32'(got_l[1]) : 32'hDEAD, 32'd0);
`ifdef DECIM_AVG_EN
        ev = '{32'd0, 32'd7, 32'd0, 32'd0, 32'd0};
`else
        ev = '{32'd3, 32'd11, 32'd0, 32'd0, 32'd0};
`endif
        chk_seq("tlast", ev, 2);

        // Asynchronous reset mid-group with a word pending on m00.
        for (int k = 0; k < 13; k++) step(1'b1, 32'(k), 1'b0, 1'b0, a);
        s_tvalid = 1'b0;
        chk("pre_rst_m_tvalid", 32'(m_tvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("arst_m_tdata", m_tdata, 32'd0);
        chk("arst_s_tready", 32'(s_tready), 32'd1);
        model_clear();
        got_d.delete();
        got_l.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 100; k < 108; k++) step(1'b1, 32'(k), 1'b0, 1'b1, a);
        drain();
`ifdef DECIM_AVG_EN
        ev = '{32'd103, 32'd0, 32'd0, 32'd0, 32'd0};
`else
        ev = '{32'd107, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
        chk_seq("post_rst", ev, 1);

        // Continuous groups with m00_axis_tready toggling: input must never stall.
        n = 0;
        for (int k = 0; k < 32; k++) begin
            step(1'b1, $urandom, 1'b0, k[0], a);
            if (!a) n++;
        end
        chk("toggle_stalls", 32'(n), 32'd0);
        drain();
        got_d.delete();
        got_l.delete();

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) != 0, a);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
